// File: rtl/eth_rx_mac_filter_if.sv
// Byte-wide AXI-stream bundle used on both sides of the RX MAC filter.
// There is no tready: the producer drives a beat whenever tvalid is high.
interface eth_rx_mac_filter_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tlast;
    logic       tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser);
    modport slave  (input  tdata, input  tvalid, input  tlast, input  tuser);
endinterface

// File: rtl/eth_rx_mac_filter.sv
// Destination-MAC filter for the 8-bit RX stream from the 1G MAC.
// Every incoming beat is buffered.  The frame's first six bytes form the
// destination address, and the pass/drop decision for the frame is queued.
// The read side replays the buffered frame to m_axis or discards it.
// Optional statistics counters: define ETH_RX_FILTER_STATS_EN.
module eth_rx_mac_filter #(
    parameter int FIFO_ADDR_WIDTH = 4,
    parameter int COUNT_WIDTH     = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    eth_rx_mac_filter_if.slave     s_axis,
    eth_rx_mac_filter_if.master    m_axis,
    input  logic [47:0]            local_mac,
    input  logic                   promisc_en,
    input  logic                   bcast_en,
    input  logic                   mcast_en,
    output logic [COUNT_WIDTH-1:0] stat_pass_count,
    output logic [COUNT_WIDTH-1:0] stat_drop_count,
    output logic                   fifo_overflow
);
    localparam int AW    = FIFO_ADDR_WIDTH;
    localparam int DEPTH = 2**FIFO_ADDR_WIDTH;

    localparam logic [0:0] WR_HDR  = 1'b0;
    localparam logic [0:0] WR_BODY = 1'b1;
    localparam logic [1:0] RD_WAIT = 2'd0;
    localparam logic [1:0] RD_PASS = 2'd1;
    localparam logic [1:0] RD_DROP = 2'd2;

    // Entry layout: {tuser, tlast, tdata}
    logic [9:0]    buf_mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          buf_empty, buf_full, buf_push, buf_pop;
    logic [9:0]    rd_entry;

    logic [0:0]    wr_state;
    logic [2:0]    hdr_idx;
    logic [39:0]   dst_p0;
    logic [47:0]   dst_next;

    logic          dq_mem [2];
    logic [1:0]    dq_wr, dq_rd;
    logic          dq_empty, dq_push, dq_pop, dq_data, dq_head;

    logic [1:0]    rd_state;
    logic [7:0]    m_tdata_p1;
    logic          m_tvalid_p1, m_tlast_p1, m_tuser_p1;

    function automatic logic filter_pass(input logic [47:0] dst, input logic [47:0] mac,
                                         input logic p, input logic b, input logic m);
        logic bc;
        bc = &dst;
        return p | (dst == mac) | (b & bc) | (m & dst[40] & ~bc);
    endfunction

    assign buf_empty = (wr_ptr == rd_ptr);
    assign buf_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign buf_pop   = ((rd_state == RD_PASS) || (rd_state == RD_DROP)) && !buf_empty;
    // A pop in the same cycle frees the slot, so a full buffer still accepts.
    assign buf_push  = s_axis.tvalid && (!buf_full || buf_pop);
    assign rd_entry  = buf_mem[rd_ptr[AW-1:0]];

    assign dst_next  = {dst_p0, s_axis.tdata};
    assign dq_empty  = (dq_wr == dq_rd);
    assign dq_head   = dq_mem[dq_rd[0]];
    assign dq_pop    = (rd_state == RD_WAIT) && !dq_empty && !buf_empty;

    // Decision is made on header byte 5; an early tlast is a runt and is dropped.
    always_comb begin
        dq_push = 1'b0;
        dq_data = 1'b0;
        if (s_axis.tvalid && (wr_state == WR_HDR)) begin
            if (s_axis.tlast) begin
                dq_push = 1'b1;
            end else if (hdr_idx == 3'd5) begin
                dq_push = 1'b1;
                dq_data = filter_pass(dst_next, local_mac, promisc_en, bcast_en, mcast_en);
            end
        end
    end

    // Byte buffer and decision queue storage (data only, no reset needed).
    always_ff @(posedge clk) begin
        if (buf_push) buf_mem[wr_ptr[AW-1:0]] <= {s_axis.tuser, s_axis.tlast, s_axis.tdata};
        if (dq_push)  dq_mem[dq_wr[0]] <= dq_data;
        if (s_axis.tvalid && (wr_state == WR_HDR)) dst_p0 <= dst_next[39:0];
    end

    // Buffer pointers and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_overflow <= 1'b0;
        end else begin
            if (buf_push) wr_ptr <= wr_ptr + 1'b1;
            if (buf_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (s_axis.tvalid && !buf_push) fifo_overflow <= 1'b1;
        end
    end

    // Write-side FSM: count header bytes, then ride the body until tlast.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state <= WR_HDR;
            hdr_idx  <= 3'd0;
            dq_wr    <= 2'd0;
        end else begin
            if (dq_push) dq_wr <= dq_wr + 2'd1;
            if (s_axis.tvalid) begin
                if (wr_state == WR_HDR) begin
                    if (s_axis.tlast) begin
                        hdr_idx <= 3'd0;
                    end else if (hdr_idx == 3'd5) begin
                        hdr_idx  <= 3'd0;
                        wr_state <= WR_BODY;
                    end else begin
                        hdr_idx <= hdr_idx + 3'd1;
                    end
                end else if (s_axis.tlast) begin
                    wr_state <= WR_HDR;
                end
            end
        end
    end

    // Read-side FSM: take a decision, then replay or discard one frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state <= RD_WAIT;
            dq_rd    <= 2'd0;
        end else begin
            if (dq_pop) begin
                dq_rd    <= dq_rd + 2'd1;
                rd_state <= dq_head ? RD_PASS : RD_DROP;
            end else if (buf_pop && rd_entry[8]) begin
                rd_state <= RD_WAIT;
            end
        end
    end

    // Output register stage: valid only on cycles a passing byte is popped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_tdata_p1  <= 8'd0;
            m_tvalid_p1 <= 1'b0;
            m_tlast_p1  <= 1'b0;
            m_tuser_p1  <= 1'b0;
        end else if ((rd_state == RD_PASS) && buf_pop) begin
            m_tdata_p1  <= rd_entry[7:0];
            m_tvalid_p1 <= 1'b1;
            m_tlast_p1  <= rd_entry[8];
            m_tuser_p1  <= rd_entry[9];
        end else begin
            m_tvalid_p1 <= 1'b0;
            m_tlast_p1  <= 1'b0;
            m_tuser_p1  <= 1'b0;
        end
    end

    assign m_axis.tdata  = m_tdata_p1;
    assign m_axis.tvalid = m_tvalid_p1;
    assign m_axis.tlast  = m_tlast_p1;
    assign m_axis.tuser  = m_tuser_p1;

`ifdef ETH_RX_FILTER_STATS_EN
    // Frame counters advance when a decision leaves the queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_pass_count <= '0;
            stat_drop_count <= '0;
        end else if (dq_pop) begin
            if (dq_head) stat_pass_count <= stat_pass_count + 1'b1;
            else         stat_drop_count <= stat_drop_count + 1'b1;
        end
    end
`else
    assign stat_pass_count = '0;
    assign stat_drop_count = '0;
`endif
endmodule

// File: tb/tb_eth_rx_mac_filter.sv
// Directed bench for eth_rx_mac_filter: a table of filter vectors plus
// hand-written runt, sustained-rate, throttled/tuser and reset sequences.
module tb_eth_rx_mac_filter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [47:0] local_mac;
    logic        promisc_en, bcast_en, mcast_en;
    logic [31:0] stat_pass_count, stat_drop_count;
    logic        fifo_overflow;

    eth_rx_mac_filter_if s_if ();
    eth_rx_mac_filter_if m_if ();

    eth_rx_mac_filter #(.FIFO_ADDR_WIDTH(4), .COUNT_WIDTH(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .s_axis          (s_if),
        .m_axis          (m_if),
        .local_mac       (local_mac),
        .promisc_en      (promisc_en),
        .bcast_en        (bcast_en),
        .mcast_en        (mcast_en),
        .stat_pass_count (stat_pass_count),
        .stat_drop_count (stat_drop_count),
        .fifo_overflow   (fifo_overflow)
    );

    always #5 clk = ~clk;

`ifdef ETH_RX_FILTER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int first_cyc = -1;
    int byte5_cyc = -1;
    int exp_pass_cnt = 0;
    int exp_drop_cnt = 0;
    logic [9:0] cap_q [$];
    logic [7:0] fb [$];

    typedef struct {
        logic [47:0] dst;
        int          len;
        bit          promisc;
        bit          bcast;
        bit          mcast;
        bit          exp_pass;
    } vec_t;
    vec_t vecs [8];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (m_if.tvalid === 1'b1) begin
            if (cap_q.size() == 0) first_cyc = cyc;
            cap_q.push_back({m_if.tuser, m_if.tlast, m_if.tdata});
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        s_if.tvalid = 1'b0;
        s_if.tdata  = 8'h00;
        s_if.tlast  = 1'b0;
        s_if.tuser  = 1'b0;
    endtask

    task automatic build_frame(input logic [47:0] dst, input int len, input int seed);
        fb.delete();
        for (int i = 0; i < len; i++) begin
            if (i < 6) fb.push_back(dst[47-8*i -: 8]);
            else       fb.push_back(8'((i * 13 + seed) & 8'hFF));
        end
    endtask

    // Drives fb[0..len-1]; 'spacing' idle cycles after every beat, one idle after the frame.
    task automatic send_frame(input int len, input bit tuser_last, input int spacing);
        for (int i = 0; i < len; i++) begin
            @(posedge clk); #1;
            s_if.tvalid = 1'b1;
            s_if.tdata  = fb[i];
            s_if.tlast  = (i == len - 1);
            s_if.tuser  = (i == len - 1) && tuser_last;
            if (i == 5) byte5_cyc = cyc;
            for (int k = 0; k < spacing; k++) begin
                @(posedge clk); #1;
                drive_idle();
            end
        end
        @(posedge clk); #1;
        drive_idle();
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input string tag, input bit exp_pass, input int len, input bit tuser_last);
        idle_cycles(30);
        if (exp_pass) begin
            check({tag, "_count"}, cap_q.size(), len);
            for (int i = 0; i < len && i < cap_q.size(); i++)
                check($sformatf("%s_byte%0d", tag, i), cap_q[i],
                      {(i == len - 1) && tuser_last, i == len - 1, fb[i]});
            check({tag, "_latency"}, first_cyc - byte5_cyc, 3);
            exp_pass_cnt++;
        end else begin
            check({tag, "_dropped_count"}, cap_q.size(), 0);
            exp_drop_cnt++;
        end
        check({tag, "_stat_pass"}, stat_pass_count, STATS ? exp_pass_cnt : 0);
        check({tag, "_stat_drop"}, stat_drop_count, STATS ? exp_drop_cnt : 0);
        cap_q.delete();
    endtask

    initial begin
        local_mac  = 48'h02_00_00_00_00_01;
        promisc_en = 1'b0;
        bcast_en   = 1'b0;
        mcast_en   = 1'b0;
        drive_idle();

        vecs[0] = '{48'h02_00_00_00_00_01, 64, 0, 0, 0, 1};
        vecs[1] = '{48'h02_00_00_00_00_02, 64, 0, 0, 0, 0};
        vecs[2] = '{48'hFF_FF_FF_FF_FF_FF, 20, 0, 0, 0, 0};
        vecs[3] = '{48'hFF_FF_FF_FF_FF_FF, 20, 0, 1, 0, 1};
        vecs[4] = '{48'h01_00_5E_00_00_01, 20, 0, 0, 0, 0};
        vecs[5] = '{48'h01_00_5E_00_00_01, 20, 0, 0, 1, 1};
        vecs[6] = '{48'hFF_FF_FF_FF_FF_FF, 20, 0, 0, 1, 0};
        vecs[7] = '{48'h02_00_00_00_00_02, 20, 1, 0, 0, 1};

        // Reset state
        idle_cycles(3);
        check("rst_tvalid", m_if.tvalid, 0);
        check("rst_tdata", m_if.tdata, 0);
        check("rst_tlast", m_if.tlast, 0);
        check("rst_tuser", m_if.tuser, 0);
        check("rst_stat_pass", stat_pass_count, 0);
        check("rst_stat_drop", stat_drop_count, 0);
        check("rst_overflow", fifo_overflow, 0);
        rst_n = 1'b1;
        idle_cycles(2);

        // Table-driven filter vectors
        foreach (vecs[v]) begin
            promisc_en = vecs[v].promisc;
            bcast_en   = vecs[v].bcast;
            mcast_en   = vecs[v].mcast;
            cap_q.delete();
            build_frame(vecs[v].dst, vecs[v].len, v * 5);
            send_frame(vecs[v].len, 1'b0, 0);
            check_frame($sformatf("vec%0d", v), vecs[v].exp_pass, vecs[v].len, 1'b0);
        end
        promisc_en = 1'b0;
        bcast_en   = 1'b0;
        mcast_en   = 1'b0;

        // Runt followed one cycle later by a matching frame
        build_frame(local_mac, 4, 1);
        send_frame(4, 1'b0, 0);
        exp_drop_cnt++;
        build_frame(local_mac, 30, 2);
        send_frame(30, 1'b0, 0);
        check_frame("after_runt", 1'b1, 30, 1'b0);

        // Sustained matching frames with 12-cycle gaps
        build_frame(local_mac, 16, 3);
        for (int f = 0; f < 1000; f++) begin
            send_frame(16, 1'b0, 0);
            idle_cycles(11);
        end
        idle_cycles(30);
        check("burst_count", cap_q.size(), 16000);
        check("burst_last_byte", cap_q[cap_q.size()-1], {2'b01, fb[15]});
        check("burst_overflow", fifo_overflow, 0);
        exp_pass_cnt += 1000;
        check("burst_stat_pass", stat_pass_count, STATS ? exp_pass_cnt : 0);
        cap_q.delete();

        // Throttled input with bad-frame flag on tlast
        build_frame(local_mac, 24, 4);
        send_frame(24, 1'b1, 1);
        check_frame("throttled_tuser", 1'b1, 24, 1'b1);

        // Reset pulsed while the previous frame is still draining
        build_frame(local_mac, 40, 5);
        send_frame(40, 1'b0, 0);
        idle_cycles(1);
        check("pre_rst_tvalid", m_if.tvalid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tvalid", m_if.tvalid, 0);
        check("mid_rst_tdata", m_if.tdata, 0);
        check("mid_rst_tlast", m_if.tlast, 0);
        check("mid_rst_stat_pass", stat_pass_count, 0);
        check("mid_rst_overflow", fifo_overflow, 0);
        idle_cycles(2);
        rst_n = 1'b1;
        idle_cycles(2);
        cap_q.delete();
        exp_pass_cnt = 0;
        exp_drop_cnt = 0;
        build_frame(local_mac, 32, 6);
        send_frame(32, 1'b0, 0);
        check_frame("post_rst_pass", 1'b1, 32, 1'b0);
        build_frame(48'h02_00_00_00_00_03, 32, 7);
        send_frame(32, 1'b0, 0);
        check_frame("post_rst_drop", 1'b0, 32, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
